xcvr_clkout_freq_monitor: RTL and testbench

Multi-channel successor to the tx/rx clkout2 converter.
- Takes NUM_CH toggle signals. Each toggle is a transceiver clkout divided by 2, produced in its own domain as the _a/_b style exports.
- Measures each channel's edge rate over a fixed gate window of the system clock.
- Reports per-channel counts and a per-channel lock status with hysteresis.
- Sits beside the transceiver wrapper; feeds status/CSR logic and the test-system LEDs.

---
 rtl/xcvr_freq_mon_pkg.sv | 17 +
 rtl/xcvr_freq_mon_chan.sv | 108 ++++++++++
 rtl/xcvr_clkout_freq_monitor.sv | 93 +++++++++
 tb/tb_xcvr_clkout_freq_monitor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xcvr_freq_mon_pkg.sv
// Shared types and helpers for the multi-channel transceiver clkout frequency monitor.
package xcvr_freq_mon_pkg;

    typedef enum logic [1:0] {
        StUnlocked,
        StAcquiring,
        StLocked
    } lock_state_e;

    // Width of a counter that must hold 0..lock_windows inclusive.
    function automatic int unsigned good_cnt_width(input int unsigned lock_windows);
        int unsigned w;
        w = $clog2(lock_windows + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/xcvr_freq_mon_chan.sv
// One monitored channel: toggle synchroniser, saturating edge counter, range compare and
// lock FSM with hysteresis. The shared gate counter supplies tc.
module xcvr_freq_mon_chan
    import xcvr_freq_mon_pkg::*;
#(
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned EXP_MIN      = 24000,
    parameter int unsigned EXP_MAX      = 26000,
    parameter int unsigned LOCK_WINDOWS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             tc,
    input  logic             toggle_in,
    output logic [CNT_W-1:0] count_out,
    output logic             in_range,
    output logic             locked,
    output logic             lock_lost
);

    localparam int unsigned      GoodW      = good_cnt_width(LOCK_WINDOWS);
    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [GoodW-1:0] GoodTarget = GoodW'(LOCK_WINDOWS);

    logic             sync1_q, sync2_q, sync3_q;
    logic             edge_det;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] win_count;
    logic             win_ok;
    logic [CNT_W-1:0] count_q;
    logic             in_range_q;
    lock_state_e      state_q, state_d;
    logic [GoodW-1:0] good_q, good_d;

    // toggle_in is asynchronous; sync1/sync2 are the metastability pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= toggle_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign edge_det = sync2_q ^ sync3_q;

    // Window total including this cycle's edge, held at the saturation value.
    assign win_count = (edge_det && (cnt_q != CntMax)) ? cnt_q + CNT_W'(1) : cnt_q;

    assign win_ok = (win_count != CntMax) &&
                    (32'(win_count) >= EXP_MIN) &&
                    (32'(win_count) <= EXP_MAX);

    // The tc-cycle edge is closed into the finishing window, so the next one starts empty.
    always_comb begin
        cnt_d = win_count;
        if (!enable || tc) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (!enable) begin
            state_d = StUnlocked;
            good_d  = '0;
        end else if (tc) begin
            if (!win_ok) begin
                state_d = StUnlocked;
                good_d  = '0;
            end else begin
                if (good_q != GoodTarget) begin
                    good_d = good_q + GoodW'(1);
                end
                state_d = (good_d == GoodTarget) ? StLocked : StAcquiring;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            count_q    <= '0;
            in_range_q <= 1'b0;
            state_q    <= StUnlocked;
            good_q     <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            good_q  <= good_d;
            if (tc) begin
                count_q    <= win_count;
                in_range_q <= win_ok;
            end
        end
    end

    assign count_out = count_q;
    assign in_range  = in_range_q;
    assign locked    = (state_q == StLocked);
    assign lock_lost = (state_q == StLocked) && (state_d != StLocked);

endmodule

// File: rtl/xcvr_clkout_freq_monitor.sv
// Multi-channel clkout/2 frequency monitor: shared gate window, per-channel counts and lock.
// Optional sticky loss-of-lock flags are built when XCVR_FREQ_MON_STICKY_EN is defined.
module xcvr_clkout_freq_monitor
    import xcvr_freq_mon_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned GATE_CYCLES  = 100000,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned EXP_MIN      = 24000,
    parameter int unsigned EXP_MAX      = 26000,
    parameter int unsigned LOCK_WINDOWS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       toggle_in,
    output logic [NUM_CH*CNT_W-1:0] count_out,
    output logic                    count_valid,
    output logic [NUM_CH-1:0]       in_range,
    output logic [NUM_CH-1:0]       locked,
    output logic [NUM_CH-1:0]       sticky_lol,
    input  logic                    sticky_clr
);

    localparam int unsigned      GateW    = $clog2(GATE_CYCLES);
    localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);

    logic [GateW-1:0]  gate_q, gate_d;
    logic              tc;
    logic              count_valid_q;
    logic [NUM_CH-1:0] lock_lost;

    // Gating tc with enable discards a window whose last cycle coincides with enable falling.
    assign tc = enable && (gate_q == GateLast);

    always_comb begin
        gate_d = gate_q + GateW'(1);
        if (!enable || tc) begin
            gate_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gate_q        <= '0;
            count_valid_q <= 1'b0;
        end else begin
            gate_q        <= gate_d;
            count_valid_q <= tc;
        end
    end

    assign count_valid = count_valid_q;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
        xcvr_freq_mon_chan #(
            .CNT_W        (CNT_W),
            .EXP_MIN      (EXP_MIN),
            .EXP_MAX      (EXP_MAX),
            .LOCK_WINDOWS (LOCK_WINDOWS)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .tc        (tc),
            .toggle_in (toggle_in[n]),
            .count_out (count_out[n*CNT_W +: CNT_W]),
            .in_range  (in_range[n]),
            .locked    (locked[n]),
            .lock_lost (lock_lost[n])
        );
    end

`ifdef XCVR_FREQ_MON_STICKY_EN
    logic [NUM_CH-1:0] sticky_q;

    // A new loss of lock wins over a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= lock_lost | (sticky_q & ~{NUM_CH{sticky_clr}});
        end
    end

    assign sticky_lol = sticky_q;
`else
    logic unused_sticky;
    assign unused_sticky = ^{sticky_clr, lock_lost};
    assign sticky_lol    = '0;
`endif

endmodule

// File: tb/tb_xcvr_clkout_freq_monitor.sv
// Scoreboard bench for xcvr_clkout_freq_monitor: a windowed edge-count model predicts each
// count_valid event; a second small instance exercises counter saturation.
`timescale 1ns/1ps
module tb_xcvr_clkout_freq_monitor;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned GATE    = 1000;
    localparam int unsigned CNT_W   = 20;
    localparam int unsigned EXP_MIN = 240;
    localparam int unsigned EXP_MAX = 260;
    localparam int unsigned LW      = 3;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset, enable, sticky_clr;
    logic [NUM_CH-1:0]       toggle_in;
    logic [NUM_CH*CNT_W-1:0] count_out;
    logic                    count_valid;
    logic [NUM_CH-1:0]       in_range, locked, sticky_lol;

    logic       sat_enable;
    logic [0:0] sat_toggle;
    logic [7:0] sat_count;
    logic       sat_valid;
    logic [0:0] sat_in_range, sat_locked, sat_sticky;

    always #5 clk = ~clk;

    xcvr_clkout_freq_monitor #(
        .NUM_CH(NUM_CH), .GATE_CYCLES(GATE), .CNT_W(CNT_W),
        .EXP_MIN(EXP_MIN), .EXP_MAX(EXP_MAX), .LOCK_WINDOWS(LW)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .toggle_in(toggle_in),
        .count_out(count_out), .count_valid(count_valid), .in_range(in_range),
        .locked(locked), .sticky_lol(sticky_lol), .sticky_clr(sticky_clr)
    );

    xcvr_clkout_freq_monitor #(
        .NUM_CH(1), .GATE_CYCLES(300), .CNT_W(8),
        .EXP_MIN(240), .EXP_MAX(260), .LOCK_WINDOWS(3)
    ) u_sat (
        .clk(clk), .reset(reset), .enable(sat_enable), .toggle_in(sat_toggle),
        .count_out(sat_count), .count_valid(sat_valid), .in_range(sat_in_range),
        .locked(sat_locked), .sticky_lol(sat_sticky), .sticky_clr(sticky_clr)
    );

    typedef struct packed {
        logic [31:0]             due;
        logic [NUM_CH*CNT_W-1:0] cnt;
        logic [NUM_CH-1:0]       rng;
        logic [NUM_CH-1:0]       lck;
        logic [NUM_CH-1:0]       stk;
    } exp_t;

    exp_t sb[$];
    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int sat_seen = 0;

    // Stimulus state
    int unsigned per [NUM_CH];
    int unsigned ph  [NUM_CH];
    logic [NUM_CH-1:0] tog = '0;
    bit jitter = 1'b0;

    // Reference model state: toggle history, current window, lock bookkeeping
    logic [NUM_CH-1:0]       h1 = '0, h2 = '0, h3 = '0;
    int unsigned             wlen = 0;
    int unsigned             wcnt [NUM_CH];
    int unsigned             good [NUM_CH];
    logic [NUM_CH-1:0]       m_lock = '0, m_stk = '0, m_rng = '0;
    logic [NUM_CH*CNT_W-1:0] m_count = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A toggle change applied before clock k is counted in the window cycle at clock k+2.
    task automatic model_cycle();
        logic [NUM_CH-1:0] e;
        logic [NUM_CH-1:0] prev_lock;
        int unsigned c;
        bit pushed;
        exp_t x;
        pushed    = 1'b0;
        e         = h2 ^ h3;
        h3        = h2;
        h2        = h1;
        h1        = tog;
        prev_lock = m_lock;
        if (reset) begin
            h1 = '0; h2 = '0; h3 = '0;
            wlen = 0;
            for (int ch = 0; ch < NUM_CH; ch++) begin wcnt[ch] = 0; good[ch] = 0; end
            m_lock = '0; m_stk = '0; m_rng = '0; m_count = '0;
        end else begin
            if (!enable) begin
                wlen = 0;
                for (int ch = 0; ch < NUM_CH; ch++) begin wcnt[ch] = 0; good[ch] = 0; end
                m_lock = '0;
            end else begin
                wlen++;
                for (int ch = 0; ch < NUM_CH; ch++) wcnt[ch] += int'(e[ch]);
                if (wlen == GATE) begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        c = (wcnt[ch] > CNT_MAX) ? CNT_MAX : wcnt[ch];
                        m_count[ch*CNT_W +: CNT_W] = CNT_W'(c);
                        m_rng[ch] = (wcnt[ch] < CNT_MAX) && (c >= EXP_MIN) && (c <= EXP_MAX);
                        if (m_rng[ch]) begin
                            good[ch]++;
                            if (good[ch] >= LW) m_lock[ch] = 1'b1;
                        end else begin
                            good[ch]  = 0;
                            m_lock[ch] = 1'b0;
                        end
                        wcnt[ch] = 0;
                    end
                    wlen   = 0;
                    pushed = 1'b1;
                end
            end
`ifdef XCVR_FREQ_MON_STICKY_EN
            m_stk = (prev_lock & ~m_lock) | (m_stk & ~{NUM_CH{sticky_clr}});
`endif
        end
        if (pushed) begin
            x.due = cyc + 1;
            x.cnt = m_count;
            x.rng = m_rng;
            x.lck = m_lock;
            x.stk = m_stk;
            sb.push_back(x);
        end
    endtask

    // Drives one cycle's inputs (controls already set by the caller), models it, waits it out.
    task automatic step();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (per[ch] != 0) begin
                if (!(jitter && ($urandom_range(7) == 0))) ph[ch]++;
                if (ph[ch] >= per[ch]) begin
                    ph[ch]  = 0;
                    tog[ch] = ~tog[ch];
                end
            end
        end
        toggle_in  = tog;
        sat_toggle = ~sat_toggle;
        model_cycle();
        @(negedge clk);
    endtask

    task automatic run(input int unsigned n);
        repeat (n) step();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (count_valid) begin
            if (sb.size() == 0) begin
                check("count_valid_unexpected", count_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("count_valid_cycle", cyc, e.due);
                for (int ch = 0; ch < NUM_CH; ch++)
                    check($sformatf("count_out[%0d]", ch), count_out[ch*CNT_W +: CNT_W],
                          e.cnt[ch*CNT_W +: CNT_W]);
                check("in_range", in_range, e.rng);
                check("locked", locked, e.lck);
                check("sticky_lol", sticky_lol, e.stk);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            check("count_valid_at_due", count_valid, 1'b1);
            void'(sb.pop_front());
        end
        if (sat_valid) begin
            sat_seen++;
            check("sat_count", sat_count, 8'd255);
            check("sat_in_range", sat_in_range, 1'b0);
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; sticky_clr = 1'b0; sat_enable = 1'b0;
        toggle_in = '0; sat_toggle = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            per[ch] = 0; ph[ch] = 0; wcnt[ch] = 0; good[ch] = 0;
        end
        run(4);
        reset = 1'b0;
        run(2);
        for (int ch = 0; ch < NUM_CH; ch++)
            check($sformatf("reset_count_out[%0d]", ch), count_out[ch*CNT_W +: CNT_W], 0);
        check("reset_count_valid", count_valid, 1'b0);
        check("reset_in_range", in_range, '0);
        check("reset_locked", locked, '0);
        check("reset_sticky_lol", sticky_lol, '0);

        // Nominal: period 4 on every channel, staggered so one channel toggles on tc.
        for (int ch = 0; ch < NUM_CH; ch++) begin per[ch] = 4; ph[ch] = ch; end
        sat_enable = 1'b1;
        enable     = 1'b1;
        run(5000);
        check("nominal_locked", locked, 4'hF);

        per[2] = 3;
        run(4000);
        check("fast_ch2_unlocked", locked[2], 1'b0);
        per[2] = 4;
        run(4000);

        // Stop ch1 after relock, then clear its sticky flag.
        per[1] = 0;
        run(2500);
        check("stopped_ch1_unlocked", locked[1], 1'b0);
        sticky_clr = 1'b1;
        run(1);
        sticky_clr = 1'b0;
        run(1500);
        per[1] = 4;
        run(3300);

        // Enable drop mid-window.
        enable = 1'b0;
        run(500);
        check("disabled_locked", locked, '0);
        for (int ch = 0; ch < NUM_CH; ch++)
            check($sformatf("disabled_count_out[%0d]", ch), count_out[ch*CNT_W +: CNT_W],
                  m_count[ch*CNT_W +: CNT_W]);
        enable = 1'b1;
        run(3500);

        // Randomised periods, jitter, enable blips and sticky clears.
        jitter = 1'b1;
        repeat (12) begin
            for (int ch = 0; ch < NUM_CH; ch++) per[ch] = $urandom_range(5, 3);
            sticky_clr = ($urandom_range(3) == 0);
            run(1);
            sticky_clr = 1'b0;
            run($urandom_range(1500, 200));
            if ($urandom_range(4) == 0) begin
                enable = 1'b0;
                run($urandom_range(50, 1));
                enable = 1'b1;
            end
        end
        jitter = 1'b0;
        enable = 1'b0;
        run(10);
        check("scoreboard_drained", sb.size(), 0);
        check("sat_windows_seen", (sat_seen > 0), 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
